// File: rtl/sfp_norm.sv
// -----------------------------------------------------------------------------
// sfp_norm : special-function normalisation engine.
//
// Accepts one psum row of `col` signed elements and sums their absolute values.
// When asked, it merges a partner core's sum over a valid handshake. It then
// divides every element by (sum >> shift) with `col` parallel restoring
// dividers, which produce one quotient bit per cycle. The normalised row is
// held on the output until the downstream side accepts it. Only one row is in
// flight at a time.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   in_valid       row vector present
//   in_ready       engine can accept a row (only while idle)
//   in_data        row; element k at [(k+1)*bw_psum-1 : k*bw_psum], signed
//   ext_en         merge the partner sum for this row (sampled at capture)
//   sum_out        local absolute sum offered to the partner
//   sum_out_valid  sum_out is being offered
//   sum_in         partner sum
//   sum_in_valid   partner sum present; consumed in one cycle
//   out_valid      normalised row available
//   out_ready      downstream accepts the row
//   out_data       normalised row, same packing as in_data
//   div0           sticky flag: a row was divided with a zero divisor
//   clr_div0       synchronous clear of div0 (a same-cycle set wins)
// -----------------------------------------------------------------------------
module sfp_norm #(
  parameter int bw_psum = 20,
  parameter int col     = 8,
  parameter int sum_bw  = bw_psum + 4,
  parameter int shift   = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [col*bw_psum-1:0]   in_data,
  input  logic                     ext_en,
  output logic [sum_bw-1:0]        sum_out,
  output logic                     sum_out_valid,
  input  logic [sum_bw-1:0]        sum_in,
  input  logic                     sum_in_valid,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [col*bw_psum-1:0]   out_data,
  output logic                     div0,
  input  logic                     clr_div0
);

  // Divisor width: the bits of the sum that remain after the shift.
  localparam int dw = sum_bw - shift;
  localparam int cw = $clog2(bw_psum + 1);

  localparam logic [bw_psum-1:0] one_p      = {{(bw_psum-1){1'b0}}, 1'b1};
  localparam logic [dw-1:0]      div_one_p  = {{(dw-1){1'b0}}, 1'b1};
  localparam logic [cw-1:0]      last_cnt_p = cw'(bw_psum - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SUM  = 3'd1,
    EXCH = 3'd2,
    DIV  = 3'd3,
    OUT  = 3'd4
  } state_t;

  // Two's-complement magnitude. The most negative value maps onto
  // 2^(bw_psum-1), which is still representable as an unsigned bw_psum value.
  function automatic logic [bw_psum-1:0] abs_mag(input logic [bw_psum-1:0] x);
    if (x[bw_psum-1]) begin
      abs_mag = ~x + one_p;
    end else begin
      abs_mag = x;
    end
  endfunction

  // Re-apply the element's sign to an unsigned quotient.
  function automatic logic [bw_psum-1:0] apply_sign(input logic neg,
                                                    input logic [bw_psum-1:0] q);
    if (neg) begin
      apply_sign = ~q + one_p;
    end else begin
      apply_sign = q;
    end
  endfunction

  // Unsigned add that clamps at the all-ones value instead of wrapping.
  function automatic logic [sum_bw-1:0] sat_add(input logic [sum_bw-1:0] a,
                                                input logic [sum_bw-1:0] b);
    logic [sum_bw:0] t;
    t = {1'b0, a} + {1'b0, b};
    if (t[sum_bw]) begin
      sat_add = {sum_bw{1'b1}};
    end else begin
      sat_add = t[sum_bw-1:0];
    end
  endfunction

  // Registered state
  state_t                    state_r;
  logic [col*bw_psum-1:0]    data_r;
  logic                      ext_r;
  logic [sum_bw-1:0]         sum_r;
  // Dividend/quotient shift register per element. Dividend bits leave at the
  // MSB and quotient bits enter at the LSB, so after bw_psum steps it holds
  // the quotient.
  logic [bw_psum-1:0]        mag_r   [col];
  logic                      sign_r  [col];
  logic [dw-1:0]             rem_r   [col];
  logic [cw-1:0]             cnt_r;
  logic                      in_ready_r;
  logic [sum_bw-1:0]         sum_out_r;
  logic                      sum_out_valid_r;
  logic                      out_valid_r;
  logic [col*bw_psum-1:0]    out_data_r;
  logic                      div0_r;

  // Combinational datapath
  logic [bw_psum-1:0]        abs_s      [col];
  logic [sum_bw-1:0]         sum_s;
  logic [dw-1:0]             div_raw_s;
  logic [dw-1:0]             div_s;
  logic                      dz_s;
  logic [dw:0]               rem_shift_s [col];
  logic                      ge_s        [col];
  logic [dw-1:0]             rem_next_s  [col];
  logic [bw_psum-1:0]        quo_next_s  [col];
  logic [col*bw_psum-1:0]    res_s;
  logic                      div0_set_s;

  // Absolute values of the latched row and their zero-extended sum.
  always_comb begin
    sum_s = {sum_bw{1'b0}};
    for (int k = 0; k < col; k++) begin
      abs_s[k] = abs_mag(data_r[k*bw_psum +: bw_psum]);
      sum_s    = sum_s + {{(sum_bw-bw_psum){1'b0}}, abs_s[k]};
    end
  end

  // Divisor selection: a zero divisor is replaced by 1 and flagged.
  always_comb begin
    div_raw_s = sum_r[sum_bw-1:shift];
    dz_s      = (div_raw_s == {dw{1'b0}});
    if (dz_s) begin
      div_s = div_one_p;
    end else begin
      div_s = div_raw_s;
    end
    div0_set_s = (state_r == DIV) && dz_s;
  end

  // One restoring-division step per element, plus the signed result that is
  // valid on the final step.
  always_comb begin
    res_s = {(col*bw_psum){1'b0}};
    for (int k = 0; k < col; k++) begin
      rem_shift_s[k] = {rem_r[k], mag_r[k][bw_psum-1]};
      ge_s[k]        = (rem_shift_s[k] >= {1'b0, div_s});
      // When ge_s is set the difference is below the divisor, so it fits in
      // dw bits and the low-bit subtraction is exact.
      if (ge_s[k]) begin
        rem_next_s[k] = rem_shift_s[k][dw-1:0] - div_s;
      end else begin
        rem_next_s[k] = rem_shift_s[k][dw-1:0];
      end
      quo_next_s[k] = {mag_r[k][bw_psum-2:0], ge_s[k]};
      res_s[k*bw_psum +: bw_psum] = apply_sign(sign_r[k], quo_next_s[k]);
    end
  end

  // Control FSM and datapath registers. Reset aborts any row in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= IDLE;
      data_r          <= {(col*bw_psum){1'b0}};
      ext_r           <= 1'b0;
      sum_r           <= {sum_bw{1'b0}};
      cnt_r           <= {cw{1'b0}};
      in_ready_r      <= 1'b0;
      sum_out_r       <= {sum_bw{1'b0}};
      sum_out_valid_r <= 1'b0;
      out_valid_r     <= 1'b0;
      out_data_r      <= {(col*bw_psum){1'b0}};
      for (int k = 0; k < col; k++) begin
        mag_r[k]  <= {bw_psum{1'b0}};
        sign_r[k] <= 1'b0;
        rem_r[k]  <= {dw{1'b0}};
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (in_ready_r && in_valid) begin
            data_r     <= in_data;
            ext_r      <= ext_en;
            in_ready_r <= 1'b0;
            state_r    <= SUM;
          end else begin
            // Also raises in_ready on the first edge after reset release.
            in_ready_r <= 1'b1;
          end
        end

        SUM: begin
          sum_r <= sum_s;
          cnt_r <= {cw{1'b0}};
          for (int k = 0; k < col; k++) begin
            mag_r[k]  <= abs_s[k];
            sign_r[k] <= data_r[k*bw_psum + bw_psum - 1];
            rem_r[k]  <= {dw{1'b0}};
          end
          if (ext_r) begin
            sum_out_r       <= sum_s;
            sum_out_valid_r <= 1'b1;
            state_r         <= EXCH;
          end else begin
            state_r <= DIV;
          end
        end

        EXCH: begin
          // Waits indefinitely for the partner.
          if (sum_in_valid) begin
            sum_r           <= sat_add(sum_r, sum_in);
            sum_out_valid_r <= 1'b0;
            state_r         <= DIV;
          end else begin
            sum_out_valid_r <= 1'b1;
          end
        end

        DIV: begin
          for (int k = 0; k < col; k++) begin
            rem_r[k] <= rem_next_s[k];
            mag_r[k] <= quo_next_s[k];
          end
          cnt_r <= cnt_r + {{(cw-1){1'b0}}, 1'b1};
          if (cnt_r == last_cnt_p) begin
            out_data_r  <= res_s;
            out_valid_r <= 1'b1;
            state_r     <= OUT;
          end else begin
            out_valid_r <= 1'b0;
          end
        end

        OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end

        default: begin
          state_r         <= IDLE;
          in_ready_r      <= 1'b0;
          sum_out_valid_r <= 1'b0;
          out_valid_r     <= 1'b0;
        end
      endcase
    end
  end

  // Sticky divide-by-zero flag; a set in the same cycle beats a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div0_r <= 1'b0;
    end else if (div0_set_s) begin
      div0_r <= 1'b1;
    end else if (clr_div0) begin
      div0_r <= 1'b0;
    end else begin
      div0_r <= div0_r;
    end
  end

  assign in_ready      = in_ready_r;
  assign sum_out       = sum_out_r;
  assign sum_out_valid = sum_out_valid_r;
  assign out_valid     = out_valid_r;
  assign out_data      = out_data_r;
  assign div0          = div0_r;

endmodule

// File: tb/tb_sfp_norm.sv
// -----------------------------------------------------------------------------
// tb_sfp_norm : directed self-checking bench for sfp_norm.
// An arithmetic reference model predicts each row's result and local sum.
// A negedge compare process checks the DUT against that model. Literal
// expectations pin both the model and the cycle timing.
// -----------------------------------------------------------------------------
module tb_sfp_norm;

  localparam int BW  = 20;
  localparam int COL = 8;
  localparam int SBW = 24;
  localparam int SH  = 7;
  localparam int W   = BW * COL;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic           ext_en;
  logic [SBW-1:0] sum_out;
  logic           sum_out_valid;
  logic [SBW-1:0] sum_in;
  logic           sum_in_valid;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           div0;
  logic           clr_div0;

  always #5 clk = ~clk;

  sfp_norm #(.bw_psum(BW), .col(COL), .sum_bw(SBW), .shift(SH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ext_en(ext_en),
    .sum_out(sum_out), .sum_out_valid(sum_out_valid),
    .sum_in(sum_in), .sum_in_valid(sum_in_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .div0(div0), .clr_div0(clr_div0)
  );

  typedef struct {
    logic [W-1:0] out;
    longint       lsum;
  } rec_t;

  rec_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: sum of absolute values, optional saturating merge,
  // divisor = sum/2^SH (1 when zero), integer division truncating toward zero.
  function automatic logic [W-1:0] model(input int e[COL], input bit ext, input longint sin,
                                         output longint lsum, output bit dz);
    longint s, d, q, x;
    logic [63:0] qv;
    logic [W-1:0] r;
    s = 0;
    for (int k = 0; k < COL; k++) begin
      x = e[k];
      s += (x < 0) ? -x : x;
    end
    lsum = s;
    if (ext) begin
      s += sin;
      if (s > ((longint'(1) << SBW) - 1)) s = (longint'(1) << SBW) - 1;
    end
    d  = s / (longint'(1) << SH);
    dz = (d == 0);
    if (dz) d = 1;
    r = '0;
    for (int k = 0; k < COL; k++) begin
      x  = e[k];
      q  = x / d;
      qv = q;
      r[k*BW +: BW] = qv[BW-1:0];
    end
    return r;
  endfunction

  // Compare process: every cycle with a meaningful output is checked.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_unexpected: got out_valid=1 required no pending row");
        end else begin
          check("out_data", out_data, exp_q[0].out);
          check("in_ready_busy", W'(in_ready), W'(0));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (sum_out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sum_out_unexpected: got sum_out_valid=1 required no pending row");
        end else begin
          check("sum_out", W'(sum_out), W'(exp_q[0].lsum));
        end
      end
    end
  end

  // Send one row, serve the exchange, and collect the result.
  task automatic run_row(input int e[COL], input bit ext, input int stall,
                         input logic [SBW-1:0] sin, input int hold, input bit noise,
                         output int lat, output logic [W-1:0] res, output int sov);
    rec_t r;
    longint ls;
    bit dz, got;
    int cyc, st;
    logic [W-1:0] first;
    lat = 0; res = '0; sov = 0; cyc = 0; st = 0; got = 1'b0;
    r.out  = model(e, ext, longint'(sin), ls, dz);
    r.lsum = ls;
    for (int i = 0; i < 100 && in_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    check("in_ready_wait", W'(in_ready), W'(1));
    if (in_ready !== 1'b1) return;
    exp_q.push_back(r);
    for (int k = 0; k < COL; k++) in_data[k*BW +: BW] = e[k][BW-1:0];
    ext_en       = ext;
    in_valid     = 1'b1;
    sum_in_valid = noise && !ext;
    sum_in       = noise ? {SBW{1'b1}} : {SBW{1'b0}};
    @(posedge clk); #1;
    in_valid = 1'b0;
    ext_en   = 1'b0;
    while (!got && cyc < 300) begin
      if (ext) begin
        sum_in_valid = 1'b0;
        if (sum_out_valid) begin
          sov++;
          if (st == stall) begin
            sum_in_valid = 1'b1;
            sum_in       = sin;
          end else begin
            st++;
          end
        end
      end
      if (out_valid) begin
        got = 1'b1;
        lat = cyc + 1;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL row_timeout: got no out_valid within 300 cycles required a result");
      sum_in_valid = 1'b0;
      return;
    end
    res   = out_data;
    first = out_data;
    for (int i = 0; i < hold; i++) begin
      check("hold_in_ready", W'(in_ready), W'(0));
      @(posedge clk); #1;
      check("hold_out_valid", W'(out_valid), W'(1));
      check("hold_out_stable", out_data, first);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready    = 1'b0;
    sum_in_valid = 1'b0;
    check("out_valid_drop", W'(out_valid), W'(0));
  endtask

  // Bounds the whole run in case the DUT stalls somewhere unexpected.
  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e128[COL], e3[COL], e1[COL], emin[COL];
    int lat, sov;
    logic [W-1:0] res;
    longint ls;
    bit dz;
    logic [W-1:0] mres;

    e128 = '{128, 128, 128, 128, 128, 128, 128, 128};
    e3   = '{-256, 256, -100, 0, 0, 0, 0, 0};
    e1   = '{1, 1, 1, 1, 1, 1, 1, 1};
    emin = '{-524288, 0, 0, 0, 0, 0, 0, 0};

    // Reset held with random inputs: all outputs stay at zero.
    reset = 1'b0;
    for (int i = 0; i < 5; i++) in_data[i*32 +: 32] = $urandom();
    in_valid = 1'($urandom()); ext_en = 1'($urandom()); sum_in = SBW'($urandom());
    sum_in_valid = 1'($urandom()); out_ready = 1'($urandom()); clr_div0 = 1'($urandom());
    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready", W'(in_ready), W'(0));
      check("rst_sum_out", W'(sum_out), W'(0));
      check("rst_sum_out_valid", W'(sum_out_valid), W'(0));
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_out_data", out_data, W'(0));
      check("rst_div0", W'(div0), W'(0));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; ext_en = 1'b0; sum_in = '0; sum_in_valid = 1'b0;
    out_ready = 1'b0; clr_div0 = 1'b0; in_data = '0;
    reset = 1'b1;
    check("release_in_ready_low", W'(in_ready), W'(0));
    @(posedge clk); #1;
    check("release_in_ready_high", W'(in_ready), W'(1));

    // Literal pins on the model itself.
    mres = model(e128, 1'b1, 64'd1024, ls, dz);
    check("model_lsum", W'(ls), W'(1024));
    check("model_ext_out", mres, {8{20'd8}});
    mres = model(e3, 1'b0, 64'd0, ls, dz);
    check("model_e3_lsum", W'(ls), W'(612));
    check("model_e3_e2", W'(mres[59:40]), W'(20'hFFFE7));

    // All +128: sum 1024, d 8, result 16, latency 22.
    run_row(e128, 1'b0, 0, '0, 0, 1'b0, lat, res, sov);
    check("r128_lat", W'(lat), W'(22));
    check("r128_res", res, {8{20'd16}});

    // Signed elements with truncation toward zero.
    run_row(e3, 1'b0, 0, '0, 0, 1'b0, lat, res, sov);
    check("e3_e0", W'(res[19:0]), W'(20'hFFFC0));
    check("e3_e1", W'(res[39:20]), W'(20'd64));
    check("e3_e2", W'(res[59:40]), W'(20'hFFFE7));
    check("e3_rest", W'(res[W-1:60]), W'(0));
    check("e3_div0", W'(div0), W'(0));

    // Zero divisor: output equals input and div0 sets.
    run_row(e1, 1'b0, 0, '0, 0, 1'b0, lat, res, sov);
    check("e1_res", res, {8{20'd1}});
    check("e1_div0", W'(div0), W'(1));

    // Most negative element; stray sum_in_valid outside the exchange.
    run_row(emin, 1'b0, 0, '0, 0, 1'b1, lat, res, sov);
    check("emin_e0", W'(res[19:0]), W'(20'hFFF80));
    check("emin_lat", W'(lat), W'(22));
    check("div0_sticky", W'(div0), W'(1));
    clr_div0 = 1'b1;
    @(posedge clk); #1;
    clr_div0 = 1'b0;
    check("div0_cleared", W'(div0), W'(0));

    // Cross-core merge with 4 stall cycles.
    run_row(e128, 1'b1, 4, 24'd1024, 0, 1'b0, lat, res, sov);
    check("ext_lat", W'(lat), W'(27));
    check("ext_sov_cycles", W'(sov), W'(5));
    check("ext_res", res, {8{20'd8}});

    // Merge that saturates: divisor becomes huge, result 0.
    run_row(e128, 1'b1, 0, {SBW{1'b1}}, 0, 1'b0, lat, res, sov);
    check("sat_lat", W'(lat), W'(23));
    check("sat_res", res, W'(0));

    // Backpressure for 5 cycles.
    run_row(e3, 1'b0, 0, '0, 5, 1'b0, lat, res, sov);
    check("bp_e2", W'(res[59:40]), W'(20'hFFFE7));

    // Reset in the middle of DIV, then a clean row.
    for (int i = 0; i < 100 && in_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    begin
      rec_t r;
      r.out  = model(e128, 1'b0, 64'd0, ls, dz);
      r.lsum = ls;
      exp_q.push_back(r);
    end
    for (int k = 0; k < COL; k++) in_data[k*BW +: BW] = e128[k][BW-1:0];
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    check("midrst_out_valid", W'(out_valid), W'(0));
    check("midrst_in_ready", W'(in_ready), W'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_idle", W'(in_ready), W'(1));
    run_row(e128, 1'b0, 0, '0, 0, 1'b0, lat, res, sov);
    check("post_rst_lat", W'(lat), W'(22));
    check("post_rst_res", res, {8{20'd16}});
    check("queue_drained", W'(exp_q.size()), W'(0));

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
